// File: rtl/noc_pkg.sv
// Shared NoC physical-channel types.
// Used by both the transmit-side VC mux and the receive-side demux.
package noc_pkg;

  localparam int NOC_DATA_WIDTH = 256;
  localparam int NOC_VC_NUM     = 2;

  typedef struct packed {
    logic                      last;
    logic [NOC_DATA_WIDTH-1:0] data;
  } flit_t;

  typedef logic [$clog2(NOC_VC_NUM)-1:0] vc_idx_t;

endpackage

// File: rtl/noc_vc_fifo.sv
// Per-VC synchronous FIFO, no fall-through.
// Storage is not reset; only pointers and count are.
module noc_vc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 257,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count
             + {{AW{1'b0}}, do_push}
             - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/noc_pchannel_vc_demux_buf.sv
// Receive end of a NoC physical channel.
// Steers one-hot-valid flits into per-VC FIFOs.
module noc_pchannel_vc_demux_buf
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH   = 256,
  parameter int VCHANNEL_NUM = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [DATA_WIDTH-1:0]                   in_flit,
  input  logic                                    in_last,
  input  logic [VCHANNEL_NUM-1:0]                 in_valid,
  output logic [VCHANNEL_NUM-1:0]                 in_ready,
  output logic [VCHANNEL_NUM-1:0][DATA_WIDTH-1:0] out_flit,
  output logic [VCHANNEL_NUM-1:0]                 out_last,
  output logic [VCHANNEL_NUM-1:0]                 out_valid,
  input  logic [VCHANNEL_NUM-1:0]                 out_ready,
  output logic [VCHANNEL_NUM-1:0]                 pkt_open,
  output logic                                    err_multi
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic                    multi;
  logic [VCHANNEL_NUM-1:0] push;
  logic [VCHANNEL_NUM-1:0] pop;
  logic [VCHANNEL_NUM-1:0] full;
  logic [VCHANNEL_NUM-1:0] empty;

  // Two or more bits set: clearing the lowest set bit leaves something.
  assign multi = |(in_valid & (in_valid - VCHANNEL_NUM'(1)));

  for (genvar v = 0; v < VCHANNEL_NUM; v++) begin : g_vc
    logic [AW:0]         cnt;
    logic [DATA_WIDTH:0] head;

    assign in_ready[v]  = rst_n && (cnt != (AW+1)'(FIFO_DEPTH));
    assign push[v]      = in_valid[v] && !multi && rst_n && !full[v];
    assign out_valid[v] = !empty[v];
    assign pop[v]       = out_valid[v] && out_ready[v];
    assign out_flit[v]  = head[DATA_WIDTH-1:0];
    assign out_last[v]  = head[DATA_WIDTH];

    noc_vc_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_WIDTH+1)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[v]),
      .pop   (pop[v]),
      .din   ({in_last, in_flit}),
      .dout  (head),
      .full  (full[v]),
      .empty (empty[v]),
      .count (cnt)
    );

    // Track whether this VC is mid-packet.
    always_ff @(posedge clk) begin
      if (!rst_n)       pkt_open[v] <= 1'b0;
      else if (push[v]) pkt_open[v] <= !in_last;
    end
  end

  // Sticky protocol error on multi-hot valid.
  always_ff @(posedge clk) begin
    if (!rst_n)     err_multi <= 1'b0;
    else if (multi) err_multi <= 1'b1;
  end

endmodule
